// File: rtl/fir_serial_mac_ctrl.sv
// rtl/fir_serial_mac_ctrl.sv - serial single-MAC FIR sequencer with circular history and coefficient bank
module fir_serial_mac_ctrl #(
    parameter int TAPS = 101,
    parameter int DW   = 24,
    parameter int CW   = 24,
    parameter int AW   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    input  logic                 cfg_we,
    input  logic        [AW-1:0] cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 cfg_err,
    output logic                 busy
);

    localparam int ACCW = DW + CW + AW;
    localparam int HIW  = ACCW - CW;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAPS_A   = AW'(TAPS);
    localparam logic signed [HIW-1:0] SAT_MAX = {{(AW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [HIW-1:0] SAT_MIN = {{(AW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        [AW-1:0]   wptr_q, wptr_d;
    logic        [AW-1:0]   k_q, k_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   cfg_err_q, cfg_err_d;
    logic signed [DW-1:0]   hist_q [TAPS];
    logic signed [DW-1:0]   hist_d [TAPS];
    logic signed [CW-1:0]   coef_q [TAPS];
    logic signed [CW-1:0]   coef_d [TAPS];

    logic                   in_hs;
    logic                   last_tap;
    logic        [AW-1:0]   rd_idx;
    logic signed [DW-1:0]   hist_rd;
    logic signed [CW-1:0]   coef_rd;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [HIW-1:0]  acc_hi;
    logic signed [DW-1:0]   sat_val;

    // State and datapath registers; reset also clears history and coefficient bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            cfg_err_q  <= cfg_err_d;
            hist_q     <= hist_d;
            coef_q     <= coef_d;
        end
    end

    // Next-state logic of the IDLE -> MAC -> OUT sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_hs) state_d = S_MAC;
            S_MAC:   if (last_tap) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        out_data  = out_data_q;
        cfg_err   = cfg_err_q;
    end

    // Tap read address: newest sample minus k, wrapped modulo TAPS, and the shared MAC
    always_comb begin
        in_hs    = in_valid && (state_q == S_IDLE);
        last_tap = (k_q == LAST_IDX);
        if (wptr_q >= k_q) begin
            rd_idx = wptr_q - k_q;
        end else begin
            rd_idx = wptr_q + TAPS_A - k_q;
        end
        hist_rd = hist_q[rd_idx];
        coef_rd = coef_q[k_q];
        prod    = hist_rd * coef_rd;
        acc_sum = acc_q + {{AW{prod[DW+CW-1]}}, prod};
    end

    // Drop the fractional coefficient bits and clamp to the signed output range
    always_comb begin
        acc_hi = acc_sum[ACCW-1:CW];
        if (acc_hi > SAT_MAX) begin
            sat_val = {1'b0, {(DW - 1){1'b1}}};
        end else if (acc_hi < SAT_MIN) begin
            sat_val = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            sat_val = acc_hi[DW-1:0];
        end
    end

    // Datapath updates: history capture, accumulation, result latch, coefficient writes
    always_comb begin
        wptr_d     = wptr_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        hist_d     = hist_q;
        coef_d     = coef_q;
        cfg_err_d  = 1'b0;

        // Coefficient writes land on the same edge as a handshake, so a new run sees them
        if (cfg_we) begin
            if ((state_q == S_IDLE) && (cfg_addr <= LAST_IDX)) begin
                coef_d[cfg_addr] = cfg_data;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    hist_d[wptr_q] = in_data;
                    acc_d          = '0;
                    k_d            = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (last_tap) begin
                    out_data_d = sat_val;
                    k_d        = '0;
                    wptr_d     = (wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1);
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fir_serial_mac_ctrl.sv
// tb/tb_fir_serial_mac_ctrl.sv - directed self-checking bench for fir_serial_mac_ctrl
module tb_fir_serial_mac_ctrl;

    localparam int TAPS = 101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        cfg_we = 1'b0;
    logic [6:0]  cfg_addr = '0;
    logic [23:0] cfg_data = '0;
    logic        cfg_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic signed [23:0] mc [TAPS];
    logic signed [23:0] xs [$];

    fir_serial_mac_ctrl #(.TAPS(TAPS), .DW(24), .CW(24), .AW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        xs.delete();
        for (int i = 0; i < TAPS; i++) mc[i] = '0;
    endtask

    task automatic write_coef(input int a, input logic [23:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 7'(a);
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < TAPS) mc[a] = d;
    endtask

    task automatic send(input logic [23:0] x);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        xs.push_front(x);
        if (xs.size() > TAPS) void'(xs.pop_back());
    endtask

    task automatic wait_out(output logic [23:0] y, output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n + 1;
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        y = out_data;
    endtask

    task automatic xfer(input logic [23:0] x, output logic [23:0] y, output int lat);
        send(x);
        wait_out(y, lat);
        @(posedge clk); #1;
    endtask

    function automatic logic [23:0] model();
        longint s;
        longint sh;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < xs.size()) s += longint'(xs[k]) * longint'(mc[k]);
        end
        sh = s >>> 24;
        if (sh > 64'sd8388607) return 24'h7FFFFF;
        if (sh < -64'sd8388608) return 24'h800000;
        return sh[23:0];
    endfunction

    initial begin
        logic [23:0] y;
        logic [23:0] y0;
        logic [23:0] cv;
        int lat;
        int seen;

        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse response with coef[k] = 16k
        for (int k = 0; k < TAPS; k++) write_coef(k, 24'(16 * k));
        chk("cfg_ok_no_err", 32'(cfg_err), 32'd0);
        xfer(24'h400000, y, lat);
        chk("impulse_latency", 32'(lat), 32'd102);
        chk("impulse_n0", 32'(y), 32'd0);
        for (int n = 1; n < TAPS; n++) begin
            xfer(24'h000000, y, lat);
            chk("impulse_n", 32'(y), 32'(4 * n));
        end

        // Config rejection: out-of-range address in IDLE, then a write during MAC
        write_coef(101, 24'h00DEAD);
        chk("cfg_err_addr_pulse", 32'(cfg_err), 32'd1);
        @(posedge clk); #1;
        chk("cfg_err_addr_clear", 32'(cfg_err), 32'd0);
        send(24'h400000);
        repeat (10) @(posedge clk);
        #1;
        cfg_we   = 1'b1;
        cfg_addr = 7'd3;
        cfg_data = 24'h00BEEF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("cfg_err_mac_pulse", 32'(cfg_err), 32'd1);
        chk("cfg_mac_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("cfg_err_mac_clear", 32'(cfg_err), 32'd0);
        wait_out(y, lat);
        chk("reimpulse_n0", 32'(y), 32'd0);
        @(posedge clk); #1;
        for (int n = 1; n < 10; n++) begin
            xfer(24'h000000, y, lat);
            chk("reimpulse_n", 32'(y), 32'(4 * n));
        end

        // Positive and negative saturation
        for (int k = 0; k < TAPS; k++) write_coef(k, 24'h7FFFFF);
        for (int n = 0; n < TAPS; n++) xfer(24'h7FFFFF, y, lat);
        chk("sat_pos", 32'(y), 32'h7FFFFF);
        for (int n = 0; n < TAPS; n++) xfer(24'h800000, y, lat);
        chk("sat_neg", 32'(y), 32'h800000);

        // Backpressure: hold result for 20 cycles
        out_ready = 1'b0;
        send(24'h000000);
        wait_out(y0, lat);
        chk("bp_value", 32'(y0), 32'h800000);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_data_stable", 32'(out_data), 32'(y0));
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Wrap-around: random coefficients and samples against direct convolution
        for (int k = 0; k < TAPS; k++) begin
            cv = 24'($urandom_range(0, 524287)) - 24'd262144;
            write_coef(k, cv);
        end
        for (int n = 0; n < 250; n++) begin
            xfer(24'($urandom), y, lat);
            chk("wrap_conv", 32'(y), 32'(model()));
        end

        // Reset in the middle of a MAC run
        send(24'h123456);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        xfer(24'h400000, y, lat);
        chk("midrst_impulse_n0", 32'(y), 32'd0);
        for (int n = 1; n < 5; n++) begin
            xfer(24'h000000, y, lat);
            chk("midrst_impulse_n", 32'(y), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_serial_mac_ctrl.md
Name: fir_serial_mac_ctrl

Overview:
Sequencer for a time-multiplexed FIR. One multiplier-accumulator is shared across all taps, replacing the fully parallel 101-tap convolution in the filter datapath. The block accepts samples over a valid/ready handshake and keeps a circular sample history. It then runs TAPS MAC cycles against a runtime-loadable coefficient bank and emits one scaled, saturated result per sample. It sits between the audio sample source and downstream consumers, and owns the coefficient configuration port.

Parameters:
TAPS, 101, number of filter taps (order + 1)
DW, 24, sample and output width, signed
CW, 24, coefficient width, signed
AW, 7, address width for sample/coefficient index, must satisfy 2^AW >= TAPS

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DW  signed input sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DW  signed filtered result
cfg_we  in  1  coefficient write strobe
cfg_addr  in  AW  coefficient index, 0..TAPS-1
cfg_data  in  CW  signed coefficient value
cfg_err  out  1  one-cycle pulse: coefficient write rejected
busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock clk; reset is asynchronous, active-low on rst_n.
- Reset values:
  - all outputs 0 except in_ready=1
  - state=IDLE, write pointer=0, tap index=0, accumulator=0
  - all TAPS sample-history entries=0; all coefficients=0
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - in_data is written to hist[wptr]; the MAC uses this value as x[n].
    - Accumulator is cleared, k=0, next state MAC.
    - wptr advances modulo TAPS after the run: wrap TAPS-1 -> 0; non-power-of-two wrap is required.
  - MAC: one tap per cycle, k = 0..TAPS-1.
    - acc += hist[(wptr - k) mod TAPS] * coef[k], using full signed products.
    - On k == TAPS-1, next state OUT, and out_data/out_valid are registered on that transition.
  - OUT: out_valid=1; out_data is held stable until out_ready. On out_valid&&out_ready, next state IDLE.
- Latency: handshake at cycle T gives out_valid=1 at cycle T+TAPS+1 (102 cycles at default), provided the result is not stalled.
- Throughput: one sample per TAPS+2 cycles with out_ready held high; in_ready=0 in MAC and OUT.
- Arithmetic:
  - Accumulator width DW+CW+AW bits (55 at default), signed; no overflow is possible inside the accumulator.
  - Output: acc >>> (CW) arithmetically, then saturated to DW bits. Values > 2^(DW-1)-1 give 0x7FFFFF; values < -2^(DW-1) give 0x800000.
  - Otherwise out_data = acc[DW+CW-1:CW], i.e. truncation, no rounding.
- Coefficient port:
  - cfg_we in IDLE with cfg_addr < TAPS writes coef[cfg_addr] on that edge.
  - cfg_we in MAC/OUT, or with cfg_addr >= TAPS, is ignored and cfg_err=1 for the next cycle only.
  - If cfg_we and an input handshake occur in the same IDLE cycle, the write is applied first and the run started that cycle uses the new coefficient.
- busy = (state != IDLE).
- Reset asserted mid-MAC or mid-OUT aborts the run: no out_valid, history cleared, coefficients cleared, returns to IDLE with in_ready=1.
- in_valid while in_ready=0 has no effect; the source must hold the sample.

Test Plan:
- Impulse response:
  - Stimulus: load coef[k]=k*16; send 24'h400000, then 100 zeros, with out_ready=1.
  - Required: out_data for sample n equals coef[n]/4, e.g. n=1 -> 4, n=100 -> 400; first out_valid exactly 102 cycles after the first handshake.
- Saturation:
  - Positive: all coef=24'h7FFFFF; 101 samples of 24'h7FFFFF; the 101st result must be 24'h7FFFFF.
  - Negative: repeat with samples 24'h800000; the result must be 24'h800000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0, busy=1 throughout; release gives out_valid=0 and in_ready=1 on the next cycle.
- Config rejection:
  - Stimulus: cfg_we during MAC, and cfg_we in IDLE with cfg_addr=101.
  - Required: cfg_err pulses for exactly one cycle each time; coefficient bank unchanged, confirmed by a repeat impulse test.
- Wrap-around:
  - Stimulus: stream 250 random samples and compare every output against a reference model of 101-tap direct convolution with the same truncation and saturation.
  - Required: exact match, including across both wptr wraps.
- Reset mid-run:
  - Stimulus: assert rst_n=0 at MAC cycle k=50, then deassert.
  - Required: no out_valid; in_ready=1 immediately; an impulse test then returns all zeros, since coefficients are cleared.
